// File: rtl/mmio_uart_pkg.sv
// Shared definitions for the memory-mapped UART transmitter: register offsets,
// STATUS bit positions, FSM encoding and the minimum bit time.
package mmio_uart_pkg;

  localparam logic [1:0] OFS_TXDATA  = 2'd0;
  localparam logic [1:0] OFS_STATUS  = 2'd1;
  localparam logic [1:0] OFS_DIVISOR = 2'd2;

  localparam int ST_BUSY  = 0;
  localparam int ST_FULL  = 1;
  localparam int ST_EMPTY = 2;
  localparam int ST_OVF   = 3;
  localparam int ST_PAR   = 4;

  localparam logic [15:0] MIN_DIV = 16'd2;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
    S_PARITY = 3'd3,
`endif
    S_STOP   = 3'd4
  } state_e;

  // Divisors below MIN_DIV are clamped so every bit lasts at least two cycles.
  function automatic logic [15:0] eff_div(input logic [15:0] d);
    return (d < MIN_DIV) ? MIN_DIV : d;
  endfunction

endpackage

// File: rtl/mmio_uart_tx_fifo.sv
// Synchronous FIFO for queued TX bytes; push is refused when full, pop when empty.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push_i,
  input  logic                   pop_i,
  input  logic [WIDTH-1:0]       wdata_i,
  output logic [WIDTH-1:0]       rdata_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]   CNT_ONE = 1;
  localparam logic [AW-1:0] PTR_ONE = 1;
  localparam logic [AW:0]   CNT_MAX = DEPTH;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wptr_q, wptr_d, rptr_q, rptr_d;
  logic [AW:0]      count_q, count_d;
  logic             do_push, do_pop;

  assign full_o  = (count_q == CNT_MAX);
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign rdata_o = mem_q[rptr_q];

  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (do_push) wptr_d = wptr_q + PTR_ONE;
    if (do_pop)  rptr_d = rptr_q + PTR_ONE;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  // Storage needs no reset: resetting the pointers discards the contents.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q] <= wdata_i;
  end

endmodule

// File: rtl/mmio_uart_tx.sv
// Memory-mapped UART transmitter with TX FIFO, 8N1 framing by default.
// Define UART_TX_PARITY_EN to append an even-parity bit (8E1).
module mmio_uart_tx
  import mmio_uart_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR  = 32'h1001_0040,
  parameter logic [15:0] CLK_DIV    = 16'd434,
  parameter int          FIFO_DEPTH = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] Address,
  input  logic [31:0] WriteData,
  input  logic        MemWrite,
  input  logic        MemRead,
  output logic [31:0] ReadData,
  output logic        Select,
  output logic        TxD,
  output logic        TxEmptyIrq
);

`ifdef UART_TX_PARITY_EN
  localparam logic PAR_EN = 1'b1;
`else
  localparam logic PAR_EN = 1'b0;
`endif

  logic       hit, wr, push_req, ovf_clr, pop, load, tick, busy;
  logic [1:0] offset;
  logic [7:0] fifo_rdata;
  logic       fifo_full, fifo_empty;
  logic [$clog2(FIFO_DEPTH):0] fifo_count;

  state_e      state_q, state_d;
  logic [7:0]  shift_q, shift_d;
  logic [2:0]  bitcnt_q, bitcnt_d;
  logic [15:0] timer_q, timer_d, bitlen_q, bitlen_d, div_q, div_d;
  logic        ovf_q, ovf_d;
`ifdef UART_TX_PARITY_EN
  logic        par_q, par_d;
`endif

  logic unused_bits;
  assign unused_bits = ^{WriteData[31:16], fifo_count};

  assign hit      = (Address[31:4] == BASE_ADDR[31:4]) && (Address[1:0] == 2'b00);
  assign offset   = Address[3:2];
  assign Select   = hit;
  assign wr       = hit && MemWrite;
  assign push_req = wr && (offset == OFS_TXDATA);
  assign ovf_clr  = wr && (offset == OFS_STATUS) && WriteData[ST_OVF];

  sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (push_req),
    .pop_i   (pop),
    .wdata_i (WriteData[7:0]),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  always_comb begin
    ovf_d = ovf_q;
    if (ovf_clr)               ovf_d = 1'b0;
    if (push_req && fifo_full) ovf_d = 1'b1;
    div_d = div_q;
    if (wr && (offset == OFS_DIVISOR)) div_d = WriteData[15:0];
  end

  assign tick = (timer_q == 16'd0);
  assign busy = (state_q != S_IDLE);

  always_comb begin
    state_d  = state_q;
    shift_d  = shift_q;
    bitcnt_d = bitcnt_q;
    timer_d  = timer_q;
    bitlen_d = bitlen_q;
`ifdef UART_TX_PARITY_EN
    par_d    = par_q;
`endif
    load     = 1'b0;
    if (state_q != S_IDLE) timer_d = tick ? (bitlen_q - 16'd1) : (timer_q - 16'd1);
    case (state_q)
      S_IDLE:  load = !fifo_empty;
      S_START: if (tick) begin
        state_d  = S_DATA;
        bitcnt_d = 3'd0;
      end
      S_DATA:  if (tick) begin
        shift_d  = shift_q >> 1;
        bitcnt_d = bitcnt_q + 3'd1;
`ifdef UART_TX_PARITY_EN
        if (bitcnt_q == 3'd7) state_d = S_PARITY;
`else
        if (bitcnt_q == 3'd7) state_d = S_STOP;
`endif
      end
`ifdef UART_TX_PARITY_EN
      S_PARITY: if (tick) state_d = S_STOP;
`endif
      S_STOP:  if (tick) begin
        if (!fifo_empty) load = 1'b1;
        else             state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    // Bit time is latched here so DIVISOR writes only affect later frames.
    if (load) begin
      state_d  = S_START;
      shift_d  = fifo_rdata;
      bitlen_d = eff_div(div_q);
      timer_d  = eff_div(div_q) - 16'd1;
`ifdef UART_TX_PARITY_EN
      par_d    = ^fifo_rdata;
`endif
    end
  end

  assign pop = load;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      shift_q  <= 8'd0;
      bitcnt_q <= 3'd0;
      timer_q  <= 16'd0;
      bitlen_q <= MIN_DIV;
      div_q    <= CLK_DIV;
      ovf_q    <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      shift_q  <= shift_d;
      bitcnt_q <= bitcnt_d;
      timer_q  <= timer_d;
      bitlen_q <= bitlen_d;
      div_q    <= div_d;
      ovf_q    <= ovf_d;
`ifdef UART_TX_PARITY_EN
      par_q    <= par_d;
`endif
    end
  end

  // TxD decodes straight from the state register, so reset drives it high at once.
  always_comb begin
    TxD = 1'b1;
    case (state_q)
      S_START:  TxD = 1'b0;
      S_DATA:   TxD = shift_q[0];
`ifdef UART_TX_PARITY_EN
      S_PARITY: TxD = par_q;
`endif
      default:  TxD = 1'b1;
    endcase
  end

  assign TxEmptyIrq = fifo_empty && !busy;

  always_comb begin
    ReadData = 32'd0;
    if (hit && MemRead) begin
      case (offset)
        OFS_STATUS:  ReadData = {27'd0, PAR_EN, ovf_q, fifo_empty, fifo_full, busy};
        OFS_DIVISOR: ReadData = {16'd0, div_q};
        default:     ReadData = 32'd0;
      endcase
    end
  end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Scoreboard bench for mmio_uart_tx: expected frames and read data are queued by
// the stimulus and checked by independent TxD and bus-read monitors.
module tb_mmio_uart_tx;

`ifdef UART_TX_PARITY_EN
  localparam int          NBITS = 11;
  localparam logic [31:0] PARV  = 32'h10;
`else
  localparam int          NBITS = 10;
  localparam logic [31:0] PARV  = 32'h0;
`endif
  localparam logic [31:0] BASE = 32'h1001_0040;

  typedef struct {
    logic [7:0] data;
    int         bitlen;
    int         start_cyc;
  } frame_t;

  typedef struct {
    logic [31:0] data;
    logic        sel;
    logic [31:0] addr;
  } rd_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] Address = 32'd0;
  logic [31:0] WriteData = 32'd0;
  logic        MemWrite = 1'b0;
  logic        MemRead = 1'b0;
  logic [31:0] ReadData;
  logic        Select, TxD, TxEmptyIrq;

  int     cyc = 0;
  int     n_pass = 0;
  int     n_total = 0;
  logic   mon_en = 1'b1;
  logic   mon_busy = 1'b0;
  frame_t exp_q[$];
  rd_t    rd_q[$];

  mmio_uart_tx dut (
    .clk        (clk),
    .reset      (reset),
    .Address    (Address),
    .WriteData  (WriteData),
    .MemWrite   (MemWrite),
    .MemRead    (MemRead),
    .ReadData   (ReadData),
    .Select     (Select),
    .TxD        (TxD),
    .TxEmptyIrq (TxEmptyIrq)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
  endtask

  function automatic logic exp_bit(input logic [7:0] d, input int b);
    if (b == 0) return 1'b0;
    if (b <= 8) return d[b-1];
    if (NBITS == 11 && b == 9) return ^d;
    return 1'b1;
  endfunction

  // Frame monitor: on each start bit, pop the expected frame and check every cycle.
  initial begin : frame_mon
    frame_t e;
    logic   ok;
    forever begin
      @(negedge clk);
      if (mon_en && !reset && TxD === 1'b0) begin
        mon_busy = 1'b1;
        chk("frame_expected", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          if (e.start_cyc >= 0) chk($sformatf("frame_%02h_start_cyc", e.data), cyc, e.start_cyc);
          for (int b = 0; b < NBITS; b++) begin
            ok = 1'b1;
            for (int c = 0; c < e.bitlen; c++) begin
              if (!(b == 0 && c == 0)) @(negedge clk);
              if (TxD !== exp_bit(e.data, b)) ok = 1'b0;
            end
            chk($sformatf("frame_%02h_bit%0d", e.data, b), 32'(ok), 32'd1);
          end
        end else begin
          for (int i = 0; i < 2000 && TxD !== 1'b1; i++) @(negedge clk);
        end
        mon_busy = 1'b0;
      end
    end
  end

  initial begin : read_mon
    rd_t r;
    forever begin
      @(negedge clk);
      if (MemRead) begin
        chk("read_expected", 32'(rd_q.size() != 0), 32'd1);
        if (rd_q.size() != 0) begin
          r = rd_q.pop_front();
          chk($sformatf("rd_%08h_data", r.addr), ReadData, r.data);
          chk($sformatf("rd_%08h_sel", r.addr), 32'(Select), 32'(r.sel));
        end
      end
    end
  end

  task automatic sw(input logic [31:0] a, input logic [31:0] d, output int k);
    @(posedge clk); #1;
    Address = a; WriteData = d; MemWrite = 1'b1; MemRead = 1'b0;
    k = cyc + 1;
  endtask

  task automatic lw(input logic [31:0] a, input logic [31:0] exp, input logic sel);
    rd_t r;
    @(posedge clk); #1;
    Address = a; MemWrite = 1'b0; MemRead = 1'b1;
    r.data = exp; r.sel = sel; r.addr = a;
    rd_q.push_back(r);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      Address = 32'd0; MemWrite = 1'b0; MemRead = 1'b0;
    end
  endtask

  task automatic push_frame(input logic [7:0] d, input int bl, input int st);
    frame_t f;
    f.data = d; f.bitlen = bl; f.start_cyc = st;
    exp_q.push_back(f);
  endtask

  task automatic wait_frames(input string name);
    int i;
    for (i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !mon_busy) break;
    end
    chk(name, 32'(exp_q.size() == 0 && !mon_busy), 32'd1);
  endtask

  initial begin : stim
    int   k, k1, dmy;
    logic ok;

    // 1: reset state
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("reset_txd", 32'(TxD), 32'd1);
    chk("reset_irq", 32'(TxEmptyIrq), 32'd1);
    lw(BASE + 32'h4, 32'h4 | PARV, 1'b1);
    lw(BASE + 32'h8, 32'd434, 1'b1);
    idle(1);
    sw(BASE + 32'h8, 32'd4, dmy);
    idle(2);

    // 2: single frame, latency and busy
    sw(BASE, 32'h55, k);
    push_frame(8'h55, 4, k + 1);
    idle(15);
    lw(BASE + 32'h4, 32'h5 | PARV, 1'b1);
    idle(1);
    @(negedge clk);
    chk("irq_busy", 32'(TxEmptyIrq), 32'd0);
    wait_frames("drain_single");
    idle(2);
    @(negedge clk);
    chk("irq_idle", 32'(TxEmptyIrq), 32'd1);
    lw(BASE + 32'h4, 32'h4 | PARV, 1'b1);
    idle(2);

    // 3: overflow with ten back-to-back stores, then clear ovf
    k1 = 0;
    for (int i = 0; i < 10; i++) begin
      sw(BASE, 32'h10 + i, k);
      if (i == 0) k1 = k;
      if (i < 9) push_frame(8'(8'h10 + i), 4, k1 + 1 + i * NBITS * 4);
    end
    idle(1);
    lw(BASE + 32'h4, 32'hB | PARV, 1'b1);
    idle(1);
    sw(BASE + 32'h4, 32'h8, dmy);
    idle(1);
    lw(BASE + 32'h4, 32'h3 | PARV, 1'b1);
    idle(1);
    wait_frames("drain_overflow");
    idle(2);
    lw(BASE + 32'h4, 32'h4 | PARV, 1'b1);
    idle(2);

    // 4: divisor change mid-frame, then clamped divisors 1 and 0
    sw(BASE, 32'hC3, k);
    push_frame(8'hC3, 4, k + 1);
    sw(BASE, 32'h3C, dmy);
    push_frame(8'h3C, 8, k + 1 + NBITS * 4);
    idle(5);
    sw(BASE + 32'h8, 32'hABCD_0008, dmy);
    idle(1);
    lw(BASE + 32'h8, 32'h8, 1'b1);
    idle(1);
    wait_frames("drain_div8");
    idle(2);
    sw(BASE + 32'h8, 32'd1, dmy);
    sw(BASE, 32'h96, k);
    push_frame(8'h96, 2, k + 1);
    idle(1);
    lw(BASE + 32'h8, 32'h1, 1'b1);
    idle(1);
    wait_frames("drain_div1");
    idle(2);
    sw(BASE + 32'h8, 32'd0, dmy);
    sw(BASE, 32'h01, k);
    push_frame(8'h01, 2, k + 1);
    idle(1);
    wait_frames("drain_div0");
    idle(2);
    sw(BASE + 32'h8, 32'd4, dmy);
    idle(1);

    // 5: address decode misses and reserved register
    lw(32'h1001_0050, 32'h0, 1'b0);
    lw(32'h1001_0042, 32'h0, 1'b0);
    sw(32'h1001_0050, 32'h77, dmy);
    sw(32'h1001_0042, 32'h77, dmy);
    sw(BASE + 32'hC, 32'hFF, dmy);
    lw(BASE + 32'hC, 32'h0, 1'b1);
    lw(BASE + 32'h8, 32'h4, 1'b1);
    idle(60);
    @(negedge clk);
    chk("decode_no_push_irq", 32'(TxEmptyIrq), 32'd1);
    lw(BASE + 32'h4, 32'h4 | PARV, 1'b1);
    idle(2);

    // 6: reset during D3 aborts the frame and flushes the FIFO
    mon_en = 1'b0;
    sw(BASE, 32'hA5, k);
    sw(BASE, 32'h11, dmy);
    sw(BASE, 32'h22, dmy);
    idle(1);
    while (cyc < k + 18) @(negedge clk);
    chk("d3_level", 32'(TxD), 32'd0);
    reset = 1'b1;
    #1;
    chk("reset_async_txd", 32'(TxD), 32'd1);
    chk("reset_async_irq", 32'(TxEmptyIrq), 32'd1);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    ok = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (TxD !== 1'b1) ok = 1'b0;
    end
    chk("post_reset_txd_idle", 32'(ok), 32'd1);
    lw(BASE + 32'h4, 32'h4 | PARV, 1'b1);
    lw(BASE + 32'h8, 32'd434, 1'b1);
    idle(2);
    chk("reads_drained", 32'(rd_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got %0d passed of %0d", n_pass, n_total);
    $fatal(1, "timeout");
  end

endmodule
